// File: rtl/sd_quotient_to_binary_pkg.sv
// Shared definitions for the on-line divider datapath and its quotient converter.
//   sd_digit_e : radix-2 signed-digit encoding on the serial quotient stream
//   state_e    : converter FSM states
package divider_pkg;

    typedef enum logic [1:0] {
        SD_ZERO = 2'b00,
        SD_NEG  = 2'b01,
        SD_POS  = 2'b10,
        SD_BAD  = 2'b11
    } sd_digit_e;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_DONE    = 2'd2
    } state_e;

endpackage

// File: rtl/sd_quotient_to_binary_if.sv
// Handshake bundle between the quotient digit producer (master) and the
// signed-digit to two's-complement converter (slave).
//   start, digit_valid, digit           : master -> slave
//   busy, result, result_valid, digit_err : slave -> master
interface sd_quotient_to_binary_if #(
    parameter int N_DIGITS = 32
);
    logic                start;
    logic                digit_valid;
    logic [1:0]          digit;
    logic                busy;
    logic [N_DIGITS:0]   result;
    logic                result_valid;
    logic                digit_err;

    modport master (
        output start, digit_valid, digit,
        input  busy, result, result_valid, digit_err
    );

    modport slave (
        input  start, digit_valid, digit,
        output busy, result, result_valid, digit_err
    );
endinterface

// File: rtl/sd_quotient_to_binary_otf.sv
// otf_digit_update: one step of on-the-fly conversion.
//   q, qm    : current pair, invariant qm == q - 1
//   digit    : signed digit (SD_POS / SD_NEG / SD_ZERO, SD_BAD acts as zero)
//   q_next, qm_next : pair after appending the digit (invariant preserved)
//   bad      : digit was the invalid encoding
module otf_digit_update
    import divider_pkg::*;
#(
    parameter int W = 33
) (
    input  logic [W-1:0] q,
    input  logic [W-1:0] qm,
    input  logic [1:0]   digit,
    output logic [W-1:0] q_next,
    output logic [W-1:0] qm_next,
    output logic         bad
);
    // Appending a digit doubles the value; choosing the source register
    // (q or qm) absorbs the borrow of a -1 digit without any adder.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        q_next  = {q[W-2:0], 1'b0};
        qm_next = {qm[W-2:0], 1'b1};
        bad     = (digit == SD_BAD);
        case (digit)
            SD_POS: begin
                q_next  = {q[W-2:0], 1'b1};
                qm_next = {q[W-2:0], 1'b0};
            end
            SD_NEG: begin
                q_next  = {qm[W-2:0], 1'b1};
                qm_next = {qm[W-2:0], 1'b0};
            end
            default: ; // zero and invalid both append a 0 digit
        endcase
    end
endmodule

// File: rtl/sd_quotient_to_binary.sv
// sd_quotient_to_binary: converts the serial MSD-first signed-digit quotient
// into an (N_DIGITS+1)-bit two's-complement integer with the Q/QM pair.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of sd_quotient_to_binary_if (start, digit stream in;
//              busy, result, result_valid pulse, sticky digit_err out)
module sd_quotient_to_binary
    import divider_pkg::*;
#(
    parameter int N_DIGITS = 32,
    parameter int CNT_W    = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    sd_quotient_to_binary_if.slave   bus
);
    localparam int W = N_DIGITS + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_DIGITS - 1);

    state_e            state_q, state_d;
    logic [W-1:0]      q_q, q_d;
    logic [W-1:0]      qm_q, qm_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [W-1:0]      result_q, result_d;
    logic              result_valid_q, result_valid_d;
    logic              busy_q, busy_d;
    logic              digit_err_q, digit_err_d;

    logic [W-1:0]      q_next, qm_next;
    logic              bad;

    otf_digit_update #(.W(W)) u_otf (
        .q       (q_q),
        .qm      (qm_q),
        .digit   (bus.digit),
        .q_next  (q_next),
        .qm_next (qm_next),
        .bad     (bad)
    );

    always_comb begin
        state_d        = state_q;
        q_d            = q_q;
        qm_d           = qm_q;
        cnt_d          = cnt_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        digit_err_d    = digit_err_q;

        // start has priority over everything, including a final digit on the
        // same edge, so an aborted conversion never produces a pulse.
        if (bus.start) begin
            state_d     = S_CONVERT;
            q_d         = '0;
            qm_d        = '1;
            cnt_d       = '0;
            digit_err_d = 1'b0;
        end else begin
            case (state_q)
                S_CONVERT: begin
                    if (bus.digit_valid) begin
                        q_d   = q_next;
                        qm_d  = qm_next;
                        cnt_d = cnt_q + 1'b1;
                        if (bad) digit_err_d = 1'b1;
                        if (cnt_q == LAST_CNT) begin
                            result_d       = q_next;
                            result_valid_d = 1'b1;
                            state_d        = S_DONE;
                        end
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: ;
            endcase
        end

        busy_d = (state_d == S_CONVERT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            q_q            <= '0;
            qm_q           <= '1;
            cnt_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            digit_err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q        <= state_d;
            q_q            <= q_d;
            qm_q           <= qm_d;
            cnt_q          <= cnt_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            busy_q         <= busy_d;
            digit_err_q    <= digit_err_d;
        end
    end

    assign bus.busy         = busy_q;
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.digit_err    = digit_err_q;
endmodule
